index_decoder: RTL and testbench

- Inverse of the 32-bit lowest-set-bit priority encoder: rebuilds a one-hot/multi-hot bit vector from a stream of 5-bit bit indices.
- Indices arrive over a valid/ready handshake in frames terminated by a last flag. Each index is OR-ed into an accumulator.
- At frame end the completed mask is presented on a held output handshake, together with its population count.
- Sits between index-producing logic (arbiters, encoder outputs) and consumers that need the original bit vector back.

---
 rtl/index_decoder_if.sv | 29 ++
 rtl/index_decoder.sv | 127 ++++++++++++
 tb/tb_index_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/index_decoder_if.sv
// Handshake bundle for index_decoder: index beat stream in, completed mask out.
// The slave modport is the decoder's side; master is the producer/consumer side.
interface index_decoder_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             idx_valid_i;
  logic             idx_ready_o;
  logic [IDX_W-1:0] idx_i;
  logic             idx_last_i;
  logic             flush_i;
  logic             mask_valid_o;
  logic             mask_ready_i;
  logic [WIDTH-1:0] mask_o;
  logic [IDX_W:0]   count_o;
  logic             dup_o;
  logic             oor_o;

  modport slave (
    input  idx_valid_i, idx_i, idx_last_i, flush_i, mask_ready_i,
    output idx_ready_o, mask_valid_o, mask_o, count_o, dup_o, oor_o
  );

  modport master (
    output idx_valid_i, idx_i, idx_last_i, flush_i, mask_ready_i,
    input  idx_ready_o, mask_valid_o, mask_o, count_o, dup_o, oor_o
  );
endinterface

// File: rtl/index_decoder.sv
// Rebuilds a multi-hot bit vector from a framed stream of bit indices and
// presents it, with its population count, on a held output handshake.
module index_decoder #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  index_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W:0]   WIDTH_L = WIDTH[IDX_W:0];
  localparam logic [WIDTH-1:0] ONE_L   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] accum_r, accum_nxt_s;
  logic [IDX_W:0]   acc_cnt_r, acc_cnt_nxt_s;
  logic [WIDTH-1:0] mask_r, mask_nxt_s;
  logic [IDX_W:0]   count_r, count_nxt_s;
  logic             mask_valid_r, mask_valid_nxt_s;
  logic             idx_ready_r, idx_ready_nxt_s;
  logic             dup_r, dup_nxt_s;
  logic             oor_r, oor_nxt_s;

  logic             accept_s;
  logic             in_range_s;
  logic             already_s;
  logic [WIDTH-1:0] bit_s;
  logic [WIDTH-1:0] merged_s;
  logic [IDX_W:0]   merged_cnt_s;

  // Decode the incoming beat against the current accumulator.
  always_comb begin
    accept_s     = bus.idx_valid_i && idx_ready_r;
    in_range_s   = ({1'b0, bus.idx_i} < WIDTH_L);
    if (in_range_s) begin
      bit_s = ONE_L << bus.idx_i;
    end else begin
      bit_s = {WIDTH{1'b0}};
    end
    already_s    = |(accum_r & bit_s);
    merged_s     = accum_r | bit_s;
    merged_cnt_s = acc_cnt_r + {{IDX_W{1'b0}}, (in_range_s && !already_s)};
  end

  // Next-state and next-output logic; flush beats any beat on the same edge.
  always_comb begin
    state_nxt_s      = state_r;
    accum_nxt_s      = accum_r;
    acc_cnt_nxt_s    = acc_cnt_r;
    mask_nxt_s       = mask_r;
    count_nxt_s      = count_r;
    mask_valid_nxt_s = mask_valid_r;
    dup_nxt_s        = 1'b0;
    oor_nxt_s        = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        if (bus.flush_i) begin
          accum_nxt_s   = {WIDTH{1'b0}};
          acc_cnt_nxt_s = {(IDX_W+1){1'b0}};
        end else if (accept_s) begin
          dup_nxt_s = in_range_s && already_s;
          oor_nxt_s = !in_range_s;
          if (bus.idx_last_i) begin
            mask_nxt_s       = merged_s;
            count_nxt_s      = merged_cnt_s;
            mask_valid_nxt_s = 1'b1;
            accum_nxt_s      = {WIDTH{1'b0}};
            acc_cnt_nxt_s    = {(IDX_W+1){1'b0}};
            state_nxt_s      = ST_HOLD;
          end else begin
            accum_nxt_s   = merged_s;
            acc_cnt_nxt_s = merged_cnt_s;
          end
        end else begin
          accum_nxt_s = accum_r;
        end
      end
      ST_HOLD: begin
        if (mask_valid_r && bus.mask_ready_i) begin
          mask_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_ACCUM;
        end else begin
          mask_valid_nxt_s = mask_valid_r;
        end
      end
      default: begin
        state_nxt_s      = ST_ACCUM;
        mask_valid_nxt_s = 1'b0;
      end
    endcase
    idx_ready_nxt_s = (state_nxt_s == ST_ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_ACCUM;
      accum_r      <= {WIDTH{1'b0}};
      acc_cnt_r    <= {(IDX_W+1){1'b0}};
      mask_r       <= {WIDTH{1'b0}};
      count_r      <= {(IDX_W+1){1'b0}};
      mask_valid_r <= 1'b0;
      idx_ready_r  <= 1'b0;
      dup_r        <= 1'b0;
      oor_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      accum_r      <= accum_nxt_s;
      acc_cnt_r    <= acc_cnt_nxt_s;
      mask_r       <= mask_nxt_s;
      count_r      <= count_nxt_s;
      mask_valid_r <= mask_valid_nxt_s;
      idx_ready_r  <= idx_ready_nxt_s;
      dup_r        <= dup_nxt_s;
      oor_r        <= oor_nxt_s;
    end
  end

  assign bus.idx_ready_o  = idx_ready_r;
  assign bus.mask_valid_o = mask_valid_r;
  assign bus.mask_o       = mask_r;
  assign bus.count_o      = count_r;
  assign bus.dup_o        = dup_r;
  assign bus.oor_o        = oor_r;
endmodule

// File: tb/tb_index_decoder.sv
// Directed bench for index_decoder: a set-of-seen-indices model checked every
// cycle, plus literal expectations for the key frames.
module tb_index_decoder;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  index_decoder_if #(.WIDTH(WIDTH)) bus ();

  index_decoder #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: which indices have been seen in the open frame.
  bit          m_seen [WIDTH];
  bit          m_hold, m_ready, m_valid, m_dup, m_oor;
  logic [31:0] m_mask;
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_seen[k]) m_seen[k] = 1'b0;
    m_hold = 1'b0; m_ready = 1'b0; m_valid = 1'b0;
    m_dup = 1'b0; m_oor = 1'b0; m_mask = 32'h0; m_count = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit accept;
      int idx;
      accept = bus.idx_valid_i && m_ready;
      idx    = int'(bus.idx_i);
      m_dup  = 1'b0;
      m_oor  = 1'b0;
      if (!m_hold) begin
        if (bus.flush_i) begin
          foreach (m_seen[k]) m_seen[k] = 1'b0;
        end else if (accept) begin
          if (idx >= WIDTH) m_oor = 1'b1;
          else if (m_seen[idx]) m_dup = 1'b1;
          else m_seen[idx] = 1'b1;
          if (bus.idx_last_i) begin
            m_mask  = 32'h0;
            m_count = 0;
            for (int k = 0; k < WIDTH; k++) begin
              m_mask[k] = m_seen[k];
              if (m_seen[k]) m_count++;
              m_seen[k] = 1'b0;
            end
            m_hold  = 1'b1;
            m_valid = 1'b1;
          end
        end
      end else if (bus.mask_ready_i) begin
        m_hold  = 1'b0;
        m_valid = 1'b0;
      end
      m_ready = !m_hold;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    check("idx_ready", {31'h0, bus.idx_ready_o}, {31'h0, m_ready});
    check("mask_valid", {31'h0, bus.mask_valid_o}, {31'h0, m_valid});
    check("mask", bus.mask_o, m_mask);
    check("count", {26'h0, bus.count_o}, 32'(m_count));
    check("dup", {31'h0, bus.dup_o}, {31'h0, m_dup});
    check("oor", {31'h0, bus.oor_o}, {31'h0, m_oor});
  end

  function automatic int lowest_set(input logic [31:0] v);
    for (int k = 0; k < 32; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic send(input int idx, input bit last, input bit fl);
    int n = 0;
    while (!bus.idx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: idx_ready_o never rose for idx %0d", idx);
    end
    bus.idx_valid_i = 1'b1;
    bus.idx_i       = 5'(idx);
    bus.idx_last_i  = last;
    bus.flush_i     = fl;
    @(negedge clk);
    bus.idx_valid_i = 1'b0;
    bus.idx_last_i  = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.mask_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_timeout: mask_valid_o never rose", name);
    end
  endtask

  initial begin
    bus.idx_valid_i  = 1'b0;
    bus.idx_i        = 5'd0;
    bus.idx_last_i   = 1'b0;
    bus.flush_i      = 1'b0;
    bus.mask_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    #21 rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'h0, bus.idx_ready_o}, 32'h0);
    @(negedge clk);
    check("ready_after_release", {31'h0, bus.idx_ready_o}, 32'h1);

    // Frame 0,5,31
    send(0, 1'b0, 1'b0); send(5, 1'b0, 1'b0); send(31, 1'b1, 1'b0);
    wait_valid("f1");
    check("f1_mask", bus.mask_o, 32'h8000_0021);
    check("f1_count", {26'h0, bus.count_o}, 32'd3);
    @(negedge clk);
    check("f1_valid_one_cycle", {31'h0, bus.mask_valid_o}, 32'h0);

    // Duplicate index
    send(3, 1'b0, 1'b0); send(3, 1'b0, 1'b0);
    check("dup_pulse", {31'h0, bus.dup_o}, 32'h1);
    send(7, 1'b1, 1'b0);
    check("dup_cleared", {31'h0, bus.dup_o}, 32'h0);
    wait_valid("f2");
    check("f2_mask", bus.mask_o, 32'h0000_0088);
    check("f2_count", {26'h0, bus.count_o}, 32'd2);
    @(negedge clk);

    // Held output under backpressure; idx_valid_i ignored meanwhile
    bus.mask_ready_i = 1'b0;
    send(12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'h0, bus.mask_valid_o}, 32'h1);
      check("hold_mask", bus.mask_o, 32'h0000_1000);
      check("hold_ready", {31'h0, bus.idx_ready_o}, 32'h0);
      bus.idx_valid_i = (i < 4);
      bus.idx_i       = 5'd20;
      bus.mask_ready_i = (i == 4);
      @(negedge clk);
    end
    check("hold_released", {31'h0, bus.mask_valid_o}, 32'h0);
    bus.mask_ready_i = 1'b1;

    // Flush with a concurrent beat
    send(1, 1'b0, 1'b0); send(2, 1'b0, 1'b0); send(4, 1'b1, 1'b1);
    check("flush_no_emit", {31'h0, bus.mask_valid_o}, 32'h0);
    send(9, 1'b1, 1'b0);
    wait_valid("f4");
    check("f4_mask", bus.mask_o, 32'h0000_0200);
    check("f4_count", {26'h0, bus.count_o}, 32'd1);
    @(negedge clk);

    // All indices
    for (int i = 0; i < 32; i++) send(i, (i == 31), 1'b0);
    wait_valid("f5");
    check("all_mask", bus.mask_o, 32'hFFFF_FFFF);
    check("all_count", {26'h0, bus.count_o}, 32'd32);
    @(negedge clk);

    // Round trip through a lowest-set-bit encoder
    for (int k = 0; k < 32; k++) begin
      send(k, 1'b1, 1'b0);
      wait_valid("rt");
      check("rt_index", 32'(lowest_set(bus.mask_o)), 32'(k));
      check("rt_count", {26'h0, bus.count_o}, 32'd1);
      @(negedge clk);
    end

    // Asynchronous reset while holding
    bus.mask_ready_i = 1'b0;
    send(2, 1'b0, 1'b0); send(6, 1'b1, 1'b0);
    check("pre_rst_mask", bus.mask_o, 32'h0000_0044);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'h0, bus.mask_valid_o}, 32'h0);
    check("rst_mask", bus.mask_o, 32'h0);
    check("rst_count", {26'h0, bus.count_o}, 32'h0);
    check("rst_ready", {31'h0, bus.idx_ready_o}, 32'h0);
    #1 rst_n = 1'b1;
    bus.mask_ready_i = 1'b1;
    @(negedge clk);
    send(2, 1'b1, 1'b0);
    wait_valid("f6");
    check("f6_mask", bus.mask_o, 32'h0000_0004);
    check("f6_count", {26'h0, bus.count_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
